// File: rtl/rx_idle_filter_pkg.sv
// Shared constants for the receive path: comma symbol, link FSM states, FIFO defaults.
// Imported by the serial-to-parallel receiver and by rx_idle_filter.
package rx_idle_filter_pkg;

    localparam logic [7:0] COMMA_SYM     = 8'hBC;
    localparam int         DEPTH_DEF     = 4;
    localparam int         AF_THRESH_DEF = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/rx_byte_fifo.sv
// Byte FIFO with registered empty/full/almost_full; a push is refused only when full
// and not being popped in the same cycle.
module rx_byte_fifo
    import rx_idle_filter_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AF_THRESH = AF_THRESH_DEF
) (
    input  logic       clk_4f,
    input  logic       rst_L,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] head,
    output logic       empty,
    output logic       full,
    output logic       almost_full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          af_q, af_d;
    logic          wr_en, rd_en;

    always_comb begin
        rd_en    = pop && !empty_q;
        wr_en    = push && (!full_q || rd_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        cnt_d   = cnt_q + CW'(wr_en) - CW'(rd_en);
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CW'(DEPTH));
        af_d    = (cnt_d >= CW'(AF_THRESH));
    end

    always_ff @(posedge clk_4f) begin
        if (!rst_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            af_q     <= af_d;
        end
    end

    // Storage needs no reset: the pointers and count decide what is readable.
    always_ff @(posedge clk_4f) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata;
    end

    assign head        = mem_q[rd_ptr_q];
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = af_q;

endmodule

// File: rtl/rx_idle_filter.sv
// Drops comma/idle bytes and pre-sync traffic, buffers the rest for the consumer.
// Optional saturating drop counter under macro RX_IDLE_FILTER_DROP_CNT_EN.
//   state   | meaning
//   ST_IDLE | link not synchronised, every incoming byte discarded
//   ST_RUN  | link synchronised, non-comma valid bytes pushed to the FIFO
module rx_idle_filter
    import rx_idle_filter_pkg::*;
#(
    parameter int         DEPTH     = DEPTH_DEF,
    parameter int         AF_THRESH = AF_THRESH_DEF,
    parameter logic [7:0] COMMA     = COMMA_SYM
) (
    input  logic       clk_4f,
    input  logic       rst_L,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    input  logic       active_in,
    input  logic       pop,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       empty,
    output logic       full,
    output logic       almost_full,
`ifdef RX_IDLE_FILTER_DROP_CNT_EN
    output logic       overflow,
    output logic [7:0] drop_cnt
`else
    output logic       overflow
`endif
);

    state_t     state_q, state_d;
    logic [7:0] data_out_q, data_out_d;
    logic       valid_out_q, valid_out_d;
    logic       overflow_q, overflow_d;
    logic       push_req, pop_ok;
    logic [7:0] head;

    always_comb begin
        state_d     = active_in ? ST_RUN : ST_IDLE;
        push_req    = (state_q == ST_RUN) && valid_in && (data_in != COMMA);
        pop_ok      = pop && !empty;
        valid_out_d = pop_ok;
        data_out_d  = pop_ok ? head : data_out_q;
        // A pop frees the slot in the same edge, so a full FIFO only drops when nobody reads.
        overflow_d  = push_req && full && !pop_ok;
    end

    always_ff @(posedge clk_4f) begin
        if (!rst_L) begin
            state_q     <= ST_IDLE;
            data_out_q  <= 8'h00;
            valid_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            overflow_q  <= overflow_d;
        end
    end

    rx_byte_fifo #(
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH)
    ) u_fifo (
        .clk_4f      (clk_4f),
        .rst_L       (rst_L),
        .push        (push_req),
        .pop         (pop),
        .wdata       (data_in),
        .head        (head),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full)
    );

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign overflow  = overflow_q;

`ifdef RX_IDLE_FILTER_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (overflow_d && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk_4f) begin
        if (!rst_L) drop_cnt_q <= 8'h00;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_rx_idle_filter.sv
// Scoreboard bench for rx_idle_filter: directed link scenarios followed by random traffic,
// checked against a queue-based reference model.
module tb_rx_idle_filter;

    localparam int         T_DEPTH = 4;
    localparam int         T_AF    = 3;
    localparam logic [7:0] T_COMMA = 8'hBC;

    logic       clk_4f = 1'b0;
    logic       rst_L = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       active_in = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] data_out;
    logic       valid_out, empty, full, almost_full, overflow;
`ifdef RX_IDLE_FILTER_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    always #5 clk_4f = ~clk_4f;

    rx_idle_filter #(
        .DEPTH     (T_DEPTH),
        .AF_THRESH (T_AF),
        .COMMA     (T_COMMA)
    ) dut (
        .clk_4f      (clk_4f),
        .rst_L       (rst_L),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .active_in   (active_in),
        .pop         (pop),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
`ifdef RX_IDLE_FILTER_DROP_CNT_EN
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
`else
        .overflow    (overflow)
`endif
    );

    typedef struct {
        logic       valid;
        logic [7:0] dout;
        logic       empty;
        logic       full;
        logic       af;
        logic       ovf;
        logic [7:0] drop;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [7:0] m_fifo[$];
    bit         m_run = 1'b0;
    logic [7:0] m_dout = 8'h00;
    int         m_drop = 0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Drive one cycle of inputs, advance the model for the coming edge, queue the expectation.
    task automatic step(input bit rst, input bit act, input bit vld, input logic [7:0] d, input bit pp);
        exp_t e;
        bit   pop_eff;
        rst_L     = rst;
        active_in = act;
        valid_in  = vld;
        data_in   = d;
        pop       = pp;
        e.valid = 1'b0;
        e.ovf   = 1'b0;
        if (!rst) begin
            m_fifo.delete();
            m_run  = 1'b0;
            m_dout = 8'h00;
            m_drop = 0;
        end else begin
            pop_eff = pp && (m_fifo.size() > 0);
            if (pop_eff) begin
                m_dout  = m_fifo.pop_front();
                e.valid = 1'b1;
            end
            if (m_run && vld && d != T_COMMA) begin
                if (m_fifo.size() < T_DEPTH) m_fifo.push_back(d);
                else begin
                    e.ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
            m_run = act;
        end
        e.dout  = m_dout;
        e.empty = (m_fifo.size() == 0);
        e.full  = (m_fifo.size() == T_DEPTH);
        e.af    = (m_fifo.size() >= T_AF);
        e.drop  = 8'(m_drop);
        exp_q.push_back(e);
        @(negedge clk_4f);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_4f);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("valid_out", {7'b0, valid_out}, {7'b0, e.valid});
                if (e.valid) chk("data_out", data_out, e.dout);
                else         chk("data_out_hold", data_out, e.dout);
                chk("empty", {7'b0, empty}, {7'b0, e.empty});
                chk("full", {7'b0, full}, {7'b0, e.full});
                chk("almost_full", {7'b0, almost_full}, {7'b0, e.af});
                chk("overflow", {7'b0, overflow}, {7'b0, e.ovf});
`ifdef RX_IDLE_FILTER_DROP_CNT_EN
                chk("drop_cnt", drop_cnt, e.drop);
`endif
            end
        end
    end

    initial begin : driver
        logic [7:0] stream1 [9];
        logic [7:0] d;
        bit         act;
        stream1 = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hDD, 8'h45, 8'hAA, 8'hBC, 8'h13};

        step(0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 1);
        // Bytes before link sync are ignored
        step(1, 0, 1, 8'hF2, 0);
        step(1, 0, 1, 8'h15, 0);
        // Fill to full through commas
        foreach (stream1[i]) step(1, 1, 1, stream1[i], 0);
        // Comma discarded silently, DD and 45 overflow
        step(1, 1, 1, 8'hBC, 0);
        step(1, 1, 1, 8'hDD, 0);
        step(1, 1, 1, 8'h45, 0);
        // Drain, with one pop past empty
        for (int i = 0; i < 5; i++) step(1, 1, 0, 8'h00, 1);
        // Refill, then push and pop together while full
        step(1, 1, 1, 8'h01, 0);
        step(1, 1, 1, 8'h02, 0);
        step(1, 1, 1, 8'h03, 0);
        step(1, 1, 1, 8'h04, 0);
        step(1, 1, 1, 8'hDD, 1);
        step(1, 1, 0, 8'h00, 0);
        // Push and pop together while empty: push only
        for (int i = 0; i < 4; i++) step(1, 1, 0, 8'h00, 1);
        step(1, 1, 1, 8'h77, 1);
        step(1, 1, 0, 8'h00, 1);
        // Link drop keeps stored bytes poppable
        step(1, 1, 1, 8'h5A, 0);
        step(1, 0, 1, 8'h6B, 0);
        step(1, 0, 1, 8'h7C, 1);
        step(1, 0, 0, 8'h00, 0);
        // Three stored bytes, reset with a pop in the same cycle, then a pop
        step(1, 1, 1, 8'h11, 0);
        step(1, 1, 1, 8'h22, 0);
        step(1, 1, 1, 8'h33, 0);
        step(0, 1, 0, 8'h00, 1);
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 1);

        act = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) act = ~act;
            if ($urandom_range(3) == 0) d = T_COMMA;
            else                        d = 8'($urandom);
            step(($urandom_range(199) != 0), act, ($urandom_range(3) != 0), d,
                 ($urandom_range(99) < ((i / 500) % 2 == 0 ? 70 : 30)));
        end
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);

        @(posedge clk_4f);
        #2;
        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rx_idle_filter.md
RX_IDLE_FILTER -- requirements
Module: rx_idle_filter

Interface
REQ-001 Parameter DEPTH, default 4: FIFO entries, power of two, minimum 2.
REQ-002 Parameter AF_THRESH, default 3: occupancy at or above which almost_full is asserted.
REQ-003 Parameter COMMA, default 8'hBC: idle/comma symbol removed from the stream.
REQ-004 clk_4f  input  1  single byte clock; all logic rising-edge.
REQ-005 rst_L  input  1  reset, synchronous, active-low.
REQ-006 data_in  input  8  parallel byte from the serial-to-parallel receiver.
REQ-007 valid_in  input  1  data_in qualifier from the receiver.
REQ-008 active_in  input  1  receiver link-synchronised flag.
REQ-009 pop  input  1  consumer read request.
REQ-010 data_out  output  8  registered head byte.
REQ-011 valid_out  output  1  data_out qualifier, one cycle per accepted pop.
REQ-012 empty / full / almost_full  output  1 each  registered FIFO status.
REQ-013 overflow  output  1  one-cycle pulse when a byte is dropped because the FIFO is full.
REQ-014 drop_cnt  output  8  saturating drop counter; present only under the macro in REQ-030.

Function
REQ-015 FSM states: IDLE and RUN.
- IDLE -> RUN on the cycle after active_in is sampled 1.
- RUN -> IDLE on the cycle after active_in is sampled 0.
REQ-016 Push condition: state==RUN && valid_in && data_in!=COMMA; the byte is written to the tail the same edge.
REQ-017 COMMA bytes, bytes with valid_in=0, and all bytes while in IDLE are discarded silently; overflow is not asserted for these.
REQ-018 Pop condition: pop && !empty.
- data_out <= head and valid_out <= 1 at that edge (latency 1 cycle).
- Otherwise valid_out <= 0 and data_out holds its last value.
REQ-019 pop while empty is ignored: no pointer change, no error.
REQ-020 Push while full without a simultaneous pop:
- Byte dropped.
- overflow=1 for exactly one cycle.
- drop_cnt increments, saturating at 8'hFF.
REQ-021 Simultaneous push and pop while full: both succeed, occupancy unchanged, no overflow.
REQ-022 Simultaneous push and pop while empty: the pop is ignored and the push succeeds (no bypass).
REQ-023 Occupancy counter width is clog2(DEPTH)+1; read/write pointers wrap modulo DEPTH.
REQ-024 empty = (occupancy==0), full = (occupancy==DEPTH), almost_full = (occupancy>=AF_THRESH); all reflect post-edge occupancy.
REQ-025 RUN->IDLE does not flush the FIFO; stored bytes remain poppable.

Reset
REQ-026 While rst_L=0 at a clk_4f edge:
- state=IDLE; pointers and occupancy = 0.
- data_out=8'h00; valid_out=0; empty=1; full=0; almost_full=0; overflow=0; drop_cnt=0.
REQ-027 Reset asserted mid-operation discards all FIFO contents at that edge; pops in the same cycle are ignored.
REQ-028 No output changes asynchronously to clk_4f.

Configuration
REQ-029 DEPTH, AF_THRESH and COMMA are overridable at instantiation.
REQ-030 Macro RX_IDLE_FILTER_DROP_CNT_EN:
- Defined: drop_cnt port and counter exist.
- Undefined: port and counter are absent; overflow is unchanged.

Structure
REQ-031 The shared package holds COMMA_SYM=8'hBC, the IDLE/RUN state encoding, and the default DEPTH/AF_THRESH constants; the serial-to-parallel receiver and this block both import them.
REQ-032 FIFO storage and pointers sit in one sub-module, rx_byte_fifo; rx_idle_filter holds the FSM, filtering, and counter logic.

Verification
REQ-033 Stream F2,15 (valid_in=1) with active_in=0 -> no pushes, empty stays 1.
REQ-034 active_in=1, stream BC,BC,BC,BC,DD,45,AA,BC,13, no pop -> occupancy 4, full=1, no overflow.
REQ-035 Continue with BC,DD,45 (pop=0) -> BC discarded; DD and 45 each give an overflow pulse; drop_cnt=2.
REQ-036 Then pop for 5 cycles -> data_out DD,45,AA,13 with valid_out=1 on cycles 1-4, valid_out=0 on cycle 5, empty=1.
REQ-037 Full FIFO with push DD and pop on the same cycle -> head byte read out, DD stored, full stays 1, overflow=0.
REQ-038 rst_L=0 for one edge with 3 bytes stored -> all outputs at reset values on the next cycle; a later pop gives valid_out=0.
